// File: rtl/vgg16_bram_pkg.sv
// Shared widths, host-port FSM encoding and range helper for the vgg16 BRAM responder.
package vgg16_bram_pkg;

    localparam int BRAM_DATA_SIZE = 8;
    localparam int BRAM_ADDR_W    = 20;

    // One-hot, matching the layer engines' state style.
    typedef enum logic [3:0] {
        H_IDLE   = 4'b0001,
        H_ACCESS = 4'b0010,
        H_WAIT   = 4'b0100,
        H_ACK    = 4'b1000
    } host_state_e;

    function automatic logic addr_in_range(input logic [63:0] addr, input logic [63:0] depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/vgg16_bram_core.sv
// Single-port byte array with registered read, 1- or 2-stage latency and no-change
// outputs kept separately for engine reads and host reads.
module vgg16_bram_core
    import vgg16_bram_pkg::*;
#(
    parameter int DATA_W       = BRAM_DATA_SIZE,
    parameter int IDX_W        = 20,
    parameter int DEPTH        = 1048576,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc_en,
    input  logic              acc_we,
    input  logic              acc_host,
    input  logic              acc_oor,
    input  logic [IDX_W-1:0]  acc_idx,
    input  logic [DATA_W-1:0] acc_din,
    output logic [DATA_W-1:0] eng_dout,
    output logic [DATA_W-1:0] host_dout
);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic wr_en;
    logic rd_en;
    logic eng_rd;
    logic host_rd;

    always_comb begin
        wr_en   = acc_en && acc_we && !acc_oor;
        rd_en   = acc_en && !acc_we;
        eng_rd  = rd_en && !acc_host;
        host_rd = rd_en && acc_host;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[acc_idx] <= acc_din;
        end
    end

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            logic [DATA_W-1:0] eng_rd_q;
            logic [DATA_W-1:0] host_rd_q;

            // Each consumer has its own enabled read register, so a host read never
            // disturbs what the engine last saw.
            always_ff @(posedge clk) begin
                if (rst) begin
                    eng_rd_q  <= '0;
                    host_rd_q <= '0;
                end else begin
                    if (eng_rd) begin
                        eng_rd_q <= acc_oor ? '0 : mem[acc_idx];
                    end
                    if (host_rd) begin
                        host_rd_q <= acc_oor ? '0 : mem[acc_idx];
                    end
                end
            end

            assign eng_dout  = eng_rd_q;
            assign host_dout = host_rd_q;
        end else begin : g_lat2
            logic [DATA_W-1:0] raw_q;
            logic              eng_pend_q, eng_pend_d;
            logic              host_pend_q, host_pend_d;
            logic              oor_q, oor_d;
            logic [DATA_W-1:0] eng_out_q, eng_out_d;
            logic [DATA_W-1:0] host_out_q, host_out_d;

            always_ff @(posedge clk) begin
                if (rd_en) begin
                    raw_q <= mem[acc_idx];
                end
            end

            always_comb begin
                eng_pend_d  = eng_rd;
                host_pend_d = host_rd;
                oor_d       = acc_oor;
                eng_out_d   = eng_out_q;
                host_out_d  = host_out_q;
                if (eng_pend_q) begin
                    eng_out_d = oor_q ? '0 : raw_q;
                end
                if (host_pend_q) begin
                    host_out_d = oor_q ? '0 : raw_q;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    eng_pend_q  <= 1'b0;
                    host_pend_q <= 1'b0;
                    oor_q       <= 1'b0;
                    eng_out_q   <= '0;
                    host_out_q  <= '0;
                end else begin
                    eng_pend_q  <= eng_pend_d;
                    host_pend_q <= host_pend_d;
                    oor_q       <= oor_d;
                    eng_out_q   <= eng_out_d;
                    host_out_q  <= host_out_d;
                end
            end

            assign eng_dout  = eng_out_q;
            assign host_dout = host_out_q;
        end
    endgenerate

endmodule

// File: rtl/vgg16_bram_responder.sv
// Engine-facing BRAM responder: the engine port always wins, the host port borrows idle
// cycles through a req/ack FSM; adds out-of-range detection and access counters.
module vgg16_bram_responder
    import vgg16_bram_pkg::*;
#(
    parameter int DATA_SIZE    = BRAM_DATA_SIZE,
    parameter int ADDR_W       = BRAM_ADDR_W,
    parameter int DEPTH        = 1048576,
    parameter int READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vgg16_bram_ena,
    input  logic                 vgg16_bram_wea,
    input  logic [ADDR_W-1:0]    vgg16_bram_addra,
    input  logic [DATA_SIZE-1:0] vgg16_bram_dina,
    output logic [DATA_SIZE-1:0] vgg16_bram_douta,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDR_W-1:0]    host_addr,
    input  logic [DATA_SIZE-1:0] host_wdata,
    output logic                 host_ack,
    output logic [DATA_SIZE-1:0] host_rdata,
    output logic                 err_oor,
    output logic [31:0]          rd_count,
    output logic [31:0]          wr_count
);

    localparam int IDX_W = $clog2(DEPTH);

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 2 || DEPTH < 2) begin : g_bad_params
            $error("vgg16_bram_responder: READ_LATENCY must be 1 or 2 and DEPTH at least 2");
        end
    endgenerate

    host_state_e state_q, state_d;
    logic        err_oor_q, err_oor_d;
    logic [31:0] rd_count_q, rd_count_d;
    logic [31:0] wr_count_q, wr_count_d;

    logic             eng_oor;
    logic             host_oor;
    logic             host_go;
    logic             acc_en;
    logic             acc_we;
    logic             acc_host;
    logic             acc_oor;
    logic [IDX_W-1:0] acc_idx;
    logic [DATA_SIZE-1:0] acc_din;

    always_comb begin
        eng_oor  = !addr_in_range(64'(vgg16_bram_addra), 64'(DEPTH));
        host_oor = !addr_in_range(64'(host_addr), 64'(DEPTH));
        // The host only gets the RAM in a cycle the engine leaves idle.
        host_go  = (state_q == H_ACCESS) && !vgg16_bram_ena;

        state_d = state_q;
        unique case (state_q)
            H_IDLE:   if (host_req) state_d = H_ACCESS;
            H_ACCESS: if (!vgg16_bram_ena) state_d = (READ_LATENCY == 2) ? H_WAIT : H_ACK;
            H_WAIT:   state_d = H_ACK;
            H_ACK:    state_d = H_IDLE;
            default:  state_d = H_IDLE;
        endcase

        acc_en   = 1'b0;
        acc_we   = 1'b0;
        acc_host = 1'b0;
        acc_oor  = 1'b0;
        acc_idx  = vgg16_bram_addra[IDX_W-1:0];
        acc_din  = vgg16_bram_dina;
        if (!rst) begin
            if (vgg16_bram_ena) begin
                acc_en  = 1'b1;
                acc_we  = vgg16_bram_wea;
                acc_oor = eng_oor;
            end else if (host_go) begin
                acc_en   = 1'b1;
                acc_we   = host_we;
                acc_host = 1'b1;
                acc_oor  = host_oor;
                acc_idx  = host_addr[IDX_W-1:0];
                acc_din  = host_wdata;
            end
        end

        err_oor_d  = err_oor_q || (acc_en && acc_oor);
        rd_count_d = rd_count_q + 32'(vgg16_bram_ena && !vgg16_bram_wea);
        wr_count_d = wr_count_q + 32'(vgg16_bram_ena && vgg16_bram_wea);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= H_IDLE;
            err_oor_q  <= 1'b0;
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            err_oor_q  <= err_oor_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    vgg16_bram_core #(
        .DATA_W       (DATA_SIZE),
        .IDX_W        (IDX_W),
        .DEPTH        (DEPTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .acc_en    (acc_en),
        .acc_we    (acc_we),
        .acc_host  (acc_host),
        .acc_oor   (acc_oor),
        .acc_idx   (acc_idx),
        .acc_din   (acc_din),
        .eng_dout  (vgg16_bram_douta),
        .host_dout (host_rdata)
    );

    assign host_ack = (state_q == H_ACK);
    assign err_oor  = err_oor_q;
    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_vgg16_bram_responder.sv
// Scoreboard bench: a latency-1 responder under random and directed traffic, plus a
// latency-2 instance for the two-stage read path and reset during a host wait.
module tb_vgg16_bram_responder;

    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Latency-1 instance
    logic        rst, ena, wea, host_req, host_we, host_ack, err_oor;
    logic [19:0] addra, host_addr;
    logic [7:0]  dina, douta, host_wdata, host_rdata;
    logic [31:0] rd_count, wr_count;

    // Latency-2 instance
    logic        b_rst, b_ena, b_wea, b_host_req, b_host_we, b_host_ack, b_err_oor;
    logic [19:0] b_addra, b_host_addr;
    logic [7:0]  b_dina, b_douta, b_host_wdata, b_host_rdata;
    logic [31:0] b_rd_count, b_wr_count;

    vgg16_bram_responder #(.DATA_SIZE(8), .ADDR_W(20), .DEPTH(DEPTH), .READ_LATENCY(1)) dut (
        .clk(clk), .rst(rst),
        .vgg16_bram_ena(ena), .vgg16_bram_wea(wea), .vgg16_bram_addra(addra),
        .vgg16_bram_dina(dina), .vgg16_bram_douta(douta),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .err_oor(err_oor), .rd_count(rd_count), .wr_count(wr_count)
    );

    vgg16_bram_responder #(.DATA_SIZE(8), .ADDR_W(20), .DEPTH(DEPTH), .READ_LATENCY(2)) dut2 (
        .clk(clk), .rst(b_rst),
        .vgg16_bram_ena(b_ena), .vgg16_bram_wea(b_wea), .vgg16_bram_addra(b_addra),
        .vgg16_bram_dina(b_dina), .vgg16_bram_douta(b_douta),
        .host_req(b_host_req), .host_we(b_host_we), .host_addr(b_host_addr),
        .host_wdata(b_host_wdata), .host_ack(b_host_ack), .host_rdata(b_host_rdata),
        .err_oor(b_err_oor), .rd_count(b_rd_count), .wr_count(b_wr_count)
    );

    typedef struct {
        bit         is_rd;
        logic [7:0] data;
    } hexp_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] model [0:DEPTH-1];
    logic [7:0] eng_q[$];
    hexp_t      host_q[$];
    int         rd_exp = 0;
    int         wr_exp = 0;
    bit         err_exp = 1'b0;
    int         acks_seen = 0;
    int         host_issued = 0;
    bit         mon_on = 1'b0;
    bit         prev_ack = 1'b0;
    logic [7:0] douta_exp = 8'h00;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit oor(input logic [19:0] a);
        return a >= 20'(DEPTH);
    endfunction

    function automatic logic [7:0] mread(input logic [19:0] a);
        return oor(a) ? 8'h00 : model[a[9:0]];
    endfunction

    // Engine drivers: called at a negedge, drive one request, return at the next negedge.
    task automatic eng_write(input logic [19:0] a, input logic [7:0] d);
        ena = 1'b1; wea = 1'b1; addra = a; dina = d;
        if (oor(a)) err_exp = 1'b1;
        else model[a[9:0]] = d;
        wr_exp++;
        $display("eng  WR addr=%05h data=%02h", a, d);
        @(negedge clk);
    endtask

    task automatic eng_read(input logic [19:0] a);
        ena = 1'b1; wea = 1'b0; addra = a; dina = 8'($urandom);
        if (oor(a)) err_exp = 1'b1;
        eng_q.push_back(mread(a));
        rd_exp++;
        $display("eng  RD addr=%05h expect=%02h", a, mread(a));
        @(negedge clk);
    endtask

    task automatic eng_idle(input int n);
        repeat (n) begin
            ena = 1'b0; wea = 1'($urandom); addra = 20'($urandom); dina = 8'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic wait_ack(input string nm);
        int k;
        for (k = 0; k < 60; k++) begin
            @(negedge clk);
            if (host_ack) break;
        end
        chk(nm, 32'(host_ack), 32'd1);
    endtask

    task automatic host_op(input bit we, input logic [19:0] a, input logic [7:0] d);
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
        if (oor(a)) err_exp = 1'b1;
        if (we) begin
            if (!oor(a)) model[a[9:0]] = d;
            host_q.push_back('{is_rd: 1'b0, data: 8'h00});
        end else begin
            host_q.push_back('{is_rd: 1'b1, data: mread(a)});
        end
        host_issued++;
        $display("host %s addr=%05h data=%02h", we ? "WR" : "RD", a, we ? d : mread(a));
        wait_ack("host_ack_seen");
        host_req = 1'b0;
    endtask

    // Monitor for the latency-1 instance: engine reads complete one edge after sampling.
    always @(posedge clk) begin
        bit    rd_s;
        bit    r_s;
        hexp_t h;
        rd_s = ena && !wea;
        r_s  = rst;
        #1;
        if (mon_on) begin
            if (r_s) begin
                douta_exp = 8'h00;
            end else if (rd_s) begin
                if (eng_q.size() == 0) chk("eng_q_nonempty", 32'd0, 32'd1);
                else douta_exp = eng_q.pop_front();
            end
            chk(rd_s ? "douta_read" : "douta_hold", 32'(douta), 32'(douta_exp));
            if (host_ack) begin
                chk("ack_gap", 32'(prev_ack), 32'd0);
                acks_seen++;
                if (host_q.size() == 0) begin
                    chk("host_q_nonempty", 32'd0, 32'd1);
                end else begin
                    h = host_q.pop_front();
                    if (h.is_rd) chk("host_rdata", 32'(host_rdata), 32'(h.data));
                end
            end
            prev_ack = host_ack;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fall_cyc;
        int ack_cyc;
        int r;
        int k;
        logic [19:0] a;

        rst = 1'b1; ena = 1'b0; wea = 1'b0; addra = '0; dina = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        b_rst = 1'b1; b_ena = 1'b0; b_wea = 1'b0; b_addra = '0; b_dina = '0;
        b_host_req = 1'b0; b_host_we = 1'b0; b_host_addr = '0; b_host_wdata = '0;
        repeat (3) @(negedge clk);

        chk("rst_douta", 32'(douta), 32'd0);
        chk("rst_ack", 32'(host_ack), 32'd0);
        chk("rst_rdata", 32'(host_rdata), 32'd0);
        chk("rst_err", 32'(err_oor), 32'd0);
        chk("rst_rd_count", rd_count, 32'd0);
        chk("rst_wr_count", wr_count, 32'd0);
        chk("b_rst_douta", 32'(b_douta), 32'd0);
        chk("b_rst_err", 32'(b_err_oor), 32'd0);
        mon_on = 1'b1;
        rst = 1'b0; b_rst = 1'b0;

        // Write then read the same address on consecutive edges.
        eng_write(20'h00010, 8'h5A);
        eng_read(20'h00010);
        eng_idle(1);
        chk("t1_douta", 32'(douta), 32'h5A);
        chk("t1_wr_count", wr_count, 32'd1);
        chk("t1_rd_count", rd_count, 32'd1);

        // fc-style: preload 9 weights through the host, then pulse-and-sample two edges later.
        for (int i = 0; i < 9; i++) host_op(1'b1, 20'h00100 + 20'(i), 8'(i + 1));
        for (int i = 0; i < 9; i++) begin
            eng_read(20'h00100 + 20'(i));
            eng_idle(1);
            chk("fc_sample", 32'(douta), 32'(i + 1));
        end

        // Host read stalled behind 5 busy engine cycles.
        host_op(1'b1, 20'h00020, 8'h33);
        eng_read(20'h00010);
        eng_idle(1);
        fork
            begin
                repeat (5) eng_read(20'h00010);
                fall_cyc = cyc;
                eng_idle(4);
            end
            begin
                host_op(1'b0, 20'h00020, 8'h00);
                ack_cyc = cyc;
            end
        join
        chk("t3_ack_latency", 32'(ack_cyc - fall_cyc), 32'd1);
        chk("t3_douta_kept", 32'(douta), 32'h5A);

        // Out of range: write dropped (index would alias addr 0), read returns zero, sticky flag.
        host_op(1'b1, 20'h00000, 8'h11);
        chk("t4_err_clear", 32'(err_oor), 32'd0);
        eng_write(20'(DEPTH), 8'hEE);
        chk("t4_err_set", 32'(err_oor), 32'd1);
        eng_read(20'(DEPTH));
        eng_read(20'h00000);
        eng_idle(3);
        host_op(1'b0, 20'hFFFFF, 8'h00);
        chk("t4_err_sticky", 32'(err_oor), 32'd1);

        // Randomised traffic over a known region with occasional out-of-range and host ops.
        for (int i = 0; i < 64; i++) eng_write(20'h00200 + 20'(i), 8'($urandom));
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            a = 20'h00200 + 20'($urandom_range(0, 63));
            if (r < 40) eng_read(a);
            else if (r < 70) eng_write(a, 8'($urandom));
            else if (r < 74) eng_read(20'($urandom_range(DEPTH, 20'hFFFFF)));
            else if (r < 78) eng_write(20'($urandom_range(DEPTH, 20'hFFFFF)), 8'($urandom));
            else if (r < 93) eng_idle(1);
            else begin
                eng_idle(1);
                host_op(1'($urandom), a, 8'($urandom));
            end
        end
        eng_idle(2);
        chk("rand_rd_count", rd_count, 32'(rd_exp));
        chk("rand_wr_count", wr_count, 32'(wr_exp));
        chk("rand_err", 32'(err_oor), 32'(err_exp));

        // Back-to-back host writes with req held high across acks.
        host_req = 1'b1; host_we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            host_addr = 20'h00300 + 20'(i);
            host_wdata = 8'hA0 + 8'(i);
            model[host_addr[9:0]] = host_wdata;
            host_q.push_back('{is_rd: 1'b0, data: 8'h00});
            host_issued++;
            $display("host WR addr=%05h data=%02h (req held)", host_addr, host_wdata);
            wait_ack("b2b_ack_seen");
        end
        host_req = 1'b0;
        for (int i = 0; i < 3; i++) host_op(1'b0, 20'h00300 + 20'(i), 8'h00);
        for (int i = 0; i < 3; i++) eng_read(20'h00300 + 20'(i));
        eng_idle(3);
        chk("ack_count", 32'(acks_seen), 32'(host_issued));
        chk("eng_q_drained", 32'(eng_q.size()), 32'd0);
        chk("host_q_drained", 32'(host_q.size()), 32'd0);

        // Latency-2 instance: two-edge engine read, three-edge host read.
        b_ena = 1'b1; b_wea = 1'b1; b_addra = 20'h00005; b_dina = 8'h77;
        @(negedge clk);
        b_wea = 1'b0;
        @(negedge clk);
        b_ena = 1'b0;
        chk("rl2_not_yet", 32'(b_douta), 32'd0);
        @(negedge clk);
        chk("rl2_douta", 32'(b_douta), 32'h77);
        $display("eng2 RD addr=00005 douta=%02h", b_douta);
        b_host_req = 1'b1; b_host_we = 1'b0; b_host_addr = 20'h00005;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (b_host_ack) break;
        end
        b_host_req = 1'b0;
        chk("rl2_ack_lat", 32'(k), 32'd3);
        chk("rl2_host_rdata", 32'(b_host_rdata), 32'h77);
        chk("rl2_douta_kept", 32'(b_douta), 32'h77);
        $display("host2 RD addr=00005 rdata=%02h", b_host_rdata);
        b_ena = 1'b1; b_wea = 1'b1; b_addra = 20'd2000; b_dina = 8'h55;
        @(negedge clk);
        b_ena = 1'b0;
        @(negedge clk);
        chk("rl2_err_set", 32'(b_err_oor), 32'd1);
        chk("rl2_wr_count", b_wr_count, 32'd2);

        // Reset while the latency-2 host write sits in H_WAIT.
        b_host_req = 1'b1; b_host_we = 1'b1; b_host_addr = 20'h00030; b_host_wdata = 8'h99;
        @(negedge clk);
        @(negedge clk);
        b_rst = 1'b1; b_host_req = 1'b0;
        @(negedge clk);
        chk("rl2_rst_no_ack", 32'(b_host_ack), 32'd0);
        b_rst = 1'b0;
        @(negedge clk);
        chk("rl2_rst_no_ack_late", 32'(b_host_ack), 32'd0);
        chk("rl2_rst_err", 32'(b_err_oor), 32'd0);
        chk("rl2_rst_rd_count", b_rd_count, 32'd0);
        chk("rl2_rst_wr_count", b_wr_count, 32'd0);
        chk("rl2_rst_douta", 32'(b_douta), 32'd0);
        chk("rl2_rst_rdata", 32'(b_host_rdata), 32'd0);
        $display("host2 WR addr=00030 interrupted by reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
